// File: rtl/pdm_ctrl_pkg.sv
// Shared constants for the PDM capture controller: register map,
// FSM state encoding, CTRL/STATUS bit positions and size defaults.
package pdm_ctrl_pkg;

  localparam int FIFO_DEPTH_DEF = 8;
  localparam int SAMPLE_W_DEF   = 16;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_CLKDIV = 6'h04;
  localparam logic [5:0] ADDR_DATA   = 6'h08;
  localparam logic [5:0] ADDR_STATUS = 6'h0C;
  localparam logic [5:0] ADDR_PEAK   = 6'h10;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_THR_LO = 4;
  localparam int CTRL_WU_LO  = 8;

  localparam int STAT_EMPTY = 4;
  localparam int STAT_FULL  = 5;
  localparam int STAT_OVF   = 6;
  localparam int STAT_ST_LO = 8;

  localparam logic [1:0] SZ_8    = 2'b00;
  localparam logic [1:0] SZ_16   = 2'b01;
  localparam logic [1:0] SZ_32   = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/pdm_sample_fifo.sv
// Synchronous sample FIFO. Ports: clk, rst_n, push, pop, flush, wdata in;
// rdata (head), level, full, empty out. Flush beats push and pop.
module pdm_sample_fifo
  import pdm_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = SAMPLE_W_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  assign full    = level == LW'(DEPTH);
  assign empty   = level == '0;
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

endmodule

// File: rtl/tqvp_jnms_pdm_ctrl.sv
// PDM capture controller: PDM clock, idle/warm-up/run FSM, sample FIFO,
// TinyQV register bus and interrupt. Optional PEAK register: PDM_CTRL_PEAK_EN.
module tqvp_jnms_pdm_ctrl
  import pdm_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] pcm_in,
  input  logic                pcm_valid_in,
  output logic                pdm_clk_o,
  output logic                cic_clear_o,
  input  logic [5:0]          address,
  input  logic [31:0]         data_in,
  input  logic [1:0]          data_write_n,
  input  logic [1:0]          data_read_n,
  output logic [31:0]         data_out,
  output logic                data_ready,
  output logic                user_interrupt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic                en;
  logic [3:0]          thresh;
  logic [7:0]          warmup;
  logic [7:0]          clkdiv;
  logic [7:0]          wcnt;
  logic [7:0]          phase;
  logic                ovf;
  logic [LW-1:0]       level;
  logic                full;
  logic                empty;
  logic [SAMPLE_W-1:0] head;

  logic       wr_b0;
  logic       wr_b1;
  logic       wr_ctrl;
  logic       flush;
  logic       ovf_clr;
  logic       pop;
  logic       push;
  logic       drop;
  logic [3:0] thr_eff;
  logic       irq_cond;
  logic       unused;

  assign data_ready = 1'b1;
  assign unused     = ^{data_in[31:16], data_in[3:2]};

  assign wr_b0   = data_write_n != SZ_NONE;
  assign wr_b1   = data_write_n == SZ_16 || data_write_n == SZ_32;
  assign wr_ctrl = wr_b0 && address == ADDR_CTRL;
  assign flush   = wr_ctrl && data_in[CTRL_FLUSH];
  assign ovf_clr = wr_b0 && address == ADDR_STATUS && data_in[STAT_OVF];
  assign pop     = data_read_n != SZ_NONE && address == ADDR_DATA && !empty;
  assign push    = state == ST_RUN && pcm_valid_in;
  // A flushed push is discarded silently, not counted as overflow.
  assign drop    = push && full && !pop && !flush;
  assign thr_eff = (thresh == 4'd0) ? 4'd1 : thresh;
  assign irq_cond = 8'(level) >= 8'(thr_eff);

  pdm_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (pcm_in),
    .rdata (head),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en             <= 1'b0;
      thresh         <= '0;
      warmup         <= '0;
      clkdiv         <= '0;
      ovf            <= 1'b0;
      user_interrupt <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= data_in[CTRL_EN];
        thresh <= data_in[CTRL_THR_LO +: 4];
        if (wr_b1) warmup <= data_in[CTRL_WU_LO +: 8];
      end
      if (wr_b0 && address == ADDR_CLKDIV) clkdiv <= data_in[7:0];
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      user_interrupt <= irq_cond | ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wcnt        <= '0;
      phase       <= '0;
      pdm_clk_o   <= 1'b0;
      cic_clear_o <= 1'b0;
    end else begin
      cic_clear_o <= 1'b0;
      if (!en) begin
        state     <= ST_IDLE;
        phase     <= '0;
        pdm_clk_o <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            cic_clear_o <= 1'b1;
            wcnt        <= warmup;
            state       <= (warmup == 8'd0) ? ST_RUN : ST_WARMUP;
          end
          ST_WARMUP: begin
            if (pcm_valid_in) begin
              wcnt <= wcnt - 8'd1;
              if (wcnt == 8'd1) state <= ST_RUN;
            end
          end
          default: ;
        endcase
        if (state != ST_IDLE && clkdiv >= 8'd2) begin
          pdm_clk_o <= phase < (clkdiv >> 1);
          phase     <= (phase == clkdiv - 8'd1) ? 8'd0 : phase + 8'd1;
        end else begin
          pdm_clk_o <= 1'b0;
          phase     <= '0;
        end
      end
    end
  end

`ifdef PDM_CTRL_PEAK_EN
  logic [SAMPLE_W-1:0] peak;
  logic [SAMPLE_W-1:0] mag;
  logic                pushed;
  logic                peak_clr;

  // Magnitude with the most negative code saturated to the max positive.
  always_comb begin
    if (!pcm_in[SAMPLE_W-1])
      mag = pcm_in;
    else if (pcm_in == {1'b1, {(SAMPLE_W-1){1'b0}}})
      mag = {1'b0, {(SAMPLE_W-1){1'b1}}};
    else
      mag = -pcm_in;
  end

  assign pushed   = push && (!full || pop) && !flush;
  assign peak_clr = data_read_n != SZ_NONE && address == ADDR_PEAK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   peak <= '0;
    else if (peak_clr)            peak <= pushed ? mag : '0;
    else if (pushed && mag > peak) peak <= mag;
  end
`endif

  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL: begin
        data_out[CTRL_EN]          = en;
        data_out[CTRL_THR_LO +: 4] = thresh;
        data_out[CTRL_WU_LO +: 8]  = warmup;
      end
      ADDR_CLKDIV: data_out[7:0] = clkdiv;
      ADDR_DATA: begin
        if (!empty) data_out[SAMPLE_W-1:0] = head;
      end
      ADDR_STATUS: begin
        data_out[3:0]             = 4'(level);
        data_out[STAT_EMPTY]      = empty;
        data_out[STAT_FULL]       = full;
        data_out[STAT_OVF]        = ovf;
        data_out[STAT_ST_LO +: 2] = state;
      end
`ifdef PDM_CTRL_PEAK_EN
      ADDR_PEAK: data_out[SAMPLE_W-1:0] = peak;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tqvp_jnms_pdm_ctrl.sv
// Self-checking bench for tqvp_jnms_pdm_ctrl: register table, hand-timed
// corner sequences and randomized traffic against a queue-based model.
module tb_tqvp_jnms_pdm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pcm_in = '0;
  logic        pcm_valid_in = 1'b0;
  logic        pdm_clk_o;
  logic        cic_clear_o;
  logic [5:0]  address = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  tqvp_jnms_pdm_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pcm_in         (pcm_in),
    .pcm_valid_in   (pcm_valid_in),
    .pdm_clk_o      (pdm_clk_o),
    .cic_clear_o    (cic_clear_o),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d,
                           input logic [1:0] sz);
    @(negedge clk);
    address = a;
    data_in = d;
    data_write_n = sz;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    data_read_n = 2'b10;
    #1 d = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic strobe(input logic [15:0] v);
    @(negedge clk);
    pcm_in = v;
    pcm_valid_in = 1'b1;
    @(negedge clk);
    pcm_valid_in = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  wsz;
    logic [31:0] wdata;
    logic [31:0] rexp;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] rd;
  int          pdm_err, cic_err, cic_cnt, hi_cnt;
  logic        exp_pdm;

  // reference model state
  logic [15:0] q[$];
  bit          m_run, m_ovf;
  int          warm, tw, tt, thr, mag, peak_m, lvl;
  bit          do_rd, do_st, do_clr, irq_exp;
  logic [15:0] sval;
  logic [31:0] exp_st, exp_d;

  function automatic int abs_sat(input logic [15:0] s);
    int v;
    v = $signed(s);
    if (v < 0) v = -v;
    if (v > 32767) v = 32767;
    return v;
  endfunction

  initial begin
    vecs[0]  = '{6'h00, 2'b11, 32'h0, 32'h0};
    vecs[1]  = '{6'h04, 2'b11, 32'h0, 32'h0};
    vecs[2]  = '{6'h08, 2'b11, 32'h0, 32'h0};
    vecs[3]  = '{6'h0C, 2'b11, 32'h0, 32'h10};
    vecs[4]  = '{6'h10, 2'b11, 32'h0, 32'h0};
    vecs[5]  = '{6'h14, 2'b11, 32'h0, 32'h0};
    vecs[6]  = '{6'h3C, 2'b11, 32'h0, 32'h0};
    vecs[7]  = '{6'h00, 2'b10, 32'h0000_AB52, 32'h0000_AB50};
    vecs[8]  = '{6'h00, 2'b00, 32'h0000_1230, 32'h0000_AB30};
    vecs[9]  = '{6'h00, 2'b01, 32'hFFFF_0070, 32'h0000_0070};
    vecs[10] = '{6'h04, 2'b10, 32'h1234_5608, 32'h0000_0008};
    vecs[11] = '{6'h04, 2'b01, 32'h0000_0301, 32'h0000_0001};
    vecs[12] = '{6'h04, 2'b00, 32'h0000_0000, 32'h0000_0000};
    vecs[13] = '{6'h00, 2'b10, 32'h0000_0000, 32'h0000_0000};

    repeat (3) @(negedge clk);
    check("rst_pdm_clk", 32'(pdm_clk_o), 0);
    check("rst_cic_clear", 32'(cic_clear_o), 0);
    check("rst_irq", 32'(user_interrupt), 0);
    check("data_ready", 32'(data_ready), 1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].wsz != 2'b11) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wsz);
      bus_read(vecs[i].addr, rd);
      check($sformatf("reg_vec%0d", i), rd, vecs[i].rexp);
    end

    hi_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      hi_cnt += int'(pdm_clk_o);
    end
    check("pdm_idle_low", hi_cnt, 0);

    // enable: CLKDIV=8, WARMUP=2, THRESH=15
    bus_write(6'h04, 32'h8, 2'b10);
    bus_write(6'h00, 32'h0000_02F1, 2'b10);
    pdm_err = 0; cic_err = 0; cic_cnt = 0;
    for (int i = 0; i < 34; i++) begin
      if (i > 0) @(negedge clk);
      exp_pdm = (i >= 2) && (((i - 2) % 8) < 4);
      if (pdm_clk_o !== exp_pdm) pdm_err++;
      if (cic_clear_o !== (i == 1)) cic_err++;
      cic_cnt += int'(cic_clear_o);
    end
    check("pdm_clk_4hi_4lo", pdm_err, 0);
    check("cic_clear_count", cic_cnt, 1);
    check("cic_clear_timing", cic_err, 0);
    bus_read(6'h0C, rd);
    check("status_warmup", rd, 32'h110);
    for (int v = 1; v <= 5; v++) strobe(16'(v));
    bus_read(6'h0C, rd);
    check("status_after_warmup", rd, 32'h203);
    for (int v = 3; v <= 5; v++) begin
      bus_read(6'h08, rd);
      check($sformatf("data_pop_%0d", v), rd, 32'(v));
    end
    bus_read(6'h08, rd);
    check("data_empty_zero", rd, 0);

    // threshold interrupt timing
    bus_write(6'h00, 32'h0000_0241, 2'b01);
    for (int v = 10; v <= 12; v++) strobe(16'(v));
    check("irq_below_thresh", 32'(user_interrupt), 0);
    strobe(16'd13);
    check("irq_strobe_plus1", 32'(user_interrupt), 0);
    @(negedge clk);
    check("irq_strobe_plus2", 32'(user_interrupt), 1);
    bus_read(6'h08, rd);
    check("irq_pop_value", rd, 32'd10);
    check("irq_hold_after_read", 32'(user_interrupt), 1);
    @(negedge clk);
    check("irq_fall", 32'(user_interrupt), 0);

    // overflow
    bus_write(6'h00, 32'h0000_0243, 2'b01);
    bus_read(6'h0C, rd);
    check("status_flushed", rd, 32'h210);
    for (int v = 0; v < 9; v++) strobe(16'h100 + 16'(v));
    bus_read(6'h0C, rd);
    check("status_overflow", rd, 32'h268);
    check("irq_overflow", 32'(user_interrupt), 1);
    bus_write(6'h0C, 32'h40, 2'b00);
    bus_read(6'h0C, rd);
    check("status_ovf_cleared", rd, 32'h228);

    // push+pop while full
    @(negedge clk);
    pcm_in = 16'h0099; pcm_valid_in = 1'b1;
    address = 6'h08; data_read_n = 2'b10;
    #1 rd = data_out;
    @(negedge clk);
    pcm_valid_in = 1'b0; data_read_n = 2'b11;
    check("full_pushpop_head", rd, 32'h100);
    bus_read(6'h0C, rd);
    check("full_pushpop_status", rd, 32'h228);
    bus_read(6'h08, rd);
    check("full_pushpop_next", rd, 32'h101);
    strobe(16'h00AA);
    strobe(16'h00BB);
    // clear and new overflow together
    @(negedge clk);
    address = 6'h0C; data_in = 32'h40; data_write_n = 2'b00;
    pcm_in = 16'h00CC; pcm_valid_in = 1'b1;
    @(negedge clk);
    data_write_n = 2'b11; pcm_valid_in = 1'b0;
    bus_read(6'h0C, rd);
    check("ovf_set_beats_clear", rd, 32'h268);
    bus_write(6'h0C, 32'h40, 2'b00);
    bus_read(6'h0C, rd);
    check("ovf_clear_alone", rd, 32'h228);
    // flush with push
    @(negedge clk);
    address = 6'h00; data_in = 32'h0243; data_write_n = 2'b01;
    pcm_in = 16'h00DD; pcm_valid_in = 1'b1;
    @(negedge clk);
    data_write_n = 2'b11; pcm_valid_in = 1'b0;
    bus_read(6'h0C, rd);
    check("flush_beats_push", rd, 32'h210);
    // push+pop while empty
    @(negedge clk);
    pcm_in = 16'h0077; pcm_valid_in = 1'b1;
    address = 6'h08; data_read_n = 2'b10;
    #1 rd = data_out;
    @(negedge clk);
    pcm_valid_in = 1'b0; data_read_n = 2'b11;
    check("empty_pushpop_read", rd, 0);
    bus_read(6'h0C, rd);
    check("empty_pushpop_status", rd, 32'h201);
    bus_read(6'h08, rd);
    check("empty_pushpop_data", rd, 32'h77);

    // disable: FIFO retained, strobes ignored
    strobe(16'h0055);
    bus_write(6'h00, 32'h0000_0240, 2'b01);
    bus_read(6'h0C, rd);
    check("status_idle", rd, 32'h001);
    strobe(16'h0066);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hi_cnt += int'(pdm_clk_o);
    end
    check("pdm_low_disabled", hi_cnt, 0);
    bus_read(6'h0C, rd);
    check("idle_strobe_ignored", rd, 32'h001);
    bus_read(6'h08, rd);
    check("idle_retained_data", rd, 32'h55);

`ifdef PDM_CTRL_PEAK_EN
    bus_write(6'h00, 32'h0000_0043, 2'b01);
    repeat (2) @(negedge clk);
    bus_read(6'h10, rd);
    strobe(16'h0100);
    strobe(16'h8000);
    strobe(16'hFF00);
    bus_read(6'h10, rd);
    check("peak_saturated", rd, 32'h7FFF);
    bus_read(6'h10, rd);
    check("peak_read_clear", rd, 0);
`endif

    // randomized traffic against the queue model
    for (int t = 0; t < 3; t++) begin
      bus_write(6'h00, 32'h2, 2'b10);
      bus_write(6'h0C, 32'h40, 2'b00);
      repeat (2) @(negedge clk);
`ifdef PDM_CTRL_PEAK_EN
      bus_read(6'h10, rd);
`endif
      peak_m = 0;
      tw = $urandom_range(0, 4);
      tt = $urandom_range(0, 10);
      bus_write(6'h00, {16'h0, 8'(tw), 4'(tt), 4'b0001}, 2'b10);
      repeat (3) @(negedge clk);
      q.delete();
      m_ovf = 0;
      warm = tw;
      m_run = (tw == 0);
      thr = (tt == 0) ? 1 : tt;
      irq_exp = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        do_rd = $urandom_range(0, 99) < 35;
        do_st = $urandom_range(0, 99) < 45;
        do_clr = !do_rd && ($urandom_range(0, 99) < 6);
        sval = 16'($urandom);
        pcm_in = sval;
        pcm_valid_in = do_st;
        address = do_rd ? 6'h08 : 6'h0C;
        data_read_n = do_rd ? 2'b10 : 2'b11;
        data_in = 32'h40;
        data_write_n = do_clr ? 2'b00 : 2'b11;
        #1;
        lvl = q.size();
        if (do_rd) begin
          exp_d = (lvl > 0) ? {16'h0, q[0]} : 32'h0;
          check("rnd_data", data_out, exp_d);
        end else begin
          exp_st = 32'(lvl);
          exp_st[4] = (lvl == 0);
          exp_st[5] = (lvl == 8);
          exp_st[6] = m_ovf;
          exp_st[9:8] = m_run ? 2'd2 : 2'd1;
          check("rnd_status", data_out, exp_st);
        end
        if (k > 0) check("rnd_irq", 32'(user_interrupt), 32'(irq_exp));
        irq_exp = (lvl >= thr) || m_ovf;
        if (do_rd && lvl > 0) void'(q.pop_front());
        if (do_clr) m_ovf = 0;
        if (do_st) begin
          if (!m_run) begin
            warm--;
            if (warm == 0) m_run = 1;
          end else if (q.size() < 8) begin
            q.push_back(sval);
            mag = abs_sat(sval);
            if (mag > peak_m) peak_m = mag;
          end else begin
            m_ovf = 1;
          end
        end
      end
      @(negedge clk);
      pcm_valid_in = 1'b0;
      data_read_n = 2'b11;
      data_write_n = 2'b11;
`ifdef PDM_CTRL_PEAK_EN
      bus_read(6'h10, rd);
      check("rnd_peak", rd, 32'(peak_m));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
